alu_reservation_station: RTL and testbench

ALU issue queue between rename/dispatch and the ALU read stage of the physical register file. It buffers renamed ALU ops, tracks source-operand readiness, and wakes entries on the three register-file writeback broadcasts (ALU, branch, load). Each cycle it selects the oldest fully-ready entry and issues its physical tags to the ALU read port. On a mispredict it squashes entries younger than the branch.

---
 rtl/alu_reservation_station_if.sv | 57 +++++
 rtl/alu_reservation_station.sv | 151 +++++++++++++++
 tb/tb_alu_reservation_station.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_reservation_station_if.sv
// Bundle of the dispatch, writeback-broadcast, flush and issue signals that pass
// between rename/dispatch, the reservation station and the ALU read stage.
interface alu_reservation_station_if #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 7,
  parameter int ROB_W  = 4,
  parameter int CTRL_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  dispatch_valid;
  logic                  dispatch_ready;
  logic [TAG_W-1:0]      dispatch_ps1;
  logic [TAG_W-1:0]      dispatch_ps2;
  logic                  dispatch_ps1_rdy;
  logic                  dispatch_ps2_rdy;
  logic [TAG_W-1:0]      dispatch_pd;
  logic [31:0]           dispatch_imm;
  logic [CTRL_W-1:0]     dispatch_ctrl;
  logic [ROB_W-1:0]      dispatch_rob;

  logic [2:0]            wb_valid;
  logic [2:0][TAG_W-1:0] wb_tag;

  logic [ROB_W-1:0]      rob_head;
  logic                  mispredict;
  logic [ROB_W-1:0]      mispredict_rob;

  logic                  issue_valid;
  logic                  issue_ready;
  logic [TAG_W-1:0]      issue_ps1;
  logic [TAG_W-1:0]      issue_ps2;
  logic [TAG_W-1:0]      issue_pd;
  logic [31:0]           issue_imm;
  logic [CTRL_W-1:0]     issue_ctrl;
  logic [ROB_W-1:0]      issue_rob;

  logic [CNT_W-1:0]      count;

  // Upstream/downstream side: dispatch stage, writeback buses, ROB and ALU.
  modport master (
    output dispatch_valid, dispatch_ps1, dispatch_ps2, dispatch_ps1_rdy,
           dispatch_ps2_rdy, dispatch_pd, dispatch_imm, dispatch_ctrl, dispatch_rob,
           wb_valid, wb_tag, rob_head, mispredict, mispredict_rob, issue_ready,
    input  dispatch_ready, issue_valid, issue_ps1, issue_ps2, issue_pd,
           issue_imm, issue_ctrl, issue_rob, count
  );

  // Reservation station side.
  modport slave (
    input  dispatch_valid, dispatch_ps1, dispatch_ps2, dispatch_ps1_rdy,
           dispatch_ps2_rdy, dispatch_pd, dispatch_imm, dispatch_ctrl, dispatch_rob,
           wb_valid, wb_tag, rob_head, mispredict, mispredict_rob, issue_ready,
    output dispatch_ready, issue_valid, issue_ps1, issue_ps2, issue_pd,
           issue_imm, issue_ctrl, issue_rob, count
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU issue queue: buffers renamed ops, wakes sources on writeback broadcasts,
// issues the oldest fully-ready op (age relative to ROB head) and squashes
// entries younger than a mispredicting branch.
module alu_reservation_station #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 7,
  parameter int ROB_W  = 4,
  parameter int CTRL_W = 32
) (
  input logic                      clk,
  input logic                      reset,
  alu_reservation_station_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [DEPTH-1:0]  r1_q, r1_d, r2_q, r2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TAG_W-1:0]  ps1_q [DEPTH];
  logic [TAG_W-1:0]  ps2_q [DEPTH];
  logic [TAG_W-1:0]  pd_q  [DEPTH];
  logic [31:0]       imm_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_q[DEPTH];
  logic [ROB_W-1:0]  rob_q [DEPTH];

  logic              disp_fire, issue_fire, issue_vld;
  logic [IDX_W-1:0]  free_idx, sel_idx;
  logic              sel_found;
  logic [ROB_W-1:0]  sel_age;

  // Modular distance from the ROB head; the only way ROB indices are ordered.
  function automatic logic [ROB_W-1:0] age_of(input logic [ROB_W-1:0] rob,
                                              input logic [ROB_W-1:0] head);
    return rob - head;
  endfunction

  function automatic logic tag_hit(input logic [TAG_W-1:0]      tag,
                                   input logic [2:0]            wv,
                                   input logic [2:0][TAG_W-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (wv[k] && (wt[k] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Lowest free slot for allocation and oldest ready entry for issue.
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    sel_age   = '1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vld_q[i]) free_idx = IDX_W'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && r1_q[i] && r2_q[i] &&
          (!sel_found || (age_of(rob_q[i], bus.rob_head) < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age_of(rob_q[i], bus.rob_head);
      end
    end
  end

  // Dispatch acceptance only looks at registered occupancy, so a same-cycle
  // issue never opens a slot for the op being offered.
  assign bus.dispatch_ready = !reset && (cnt_q < FULL) && !bus.mispredict;
  assign issue_vld          = sel_found && !bus.mispredict;
  assign bus.issue_valid    = issue_vld;
  assign disp_fire          = bus.dispatch_valid && bus.dispatch_ready;
  assign issue_fire         = issue_vld && bus.issue_ready;
  assign bus.count          = cnt_q;

  // Issue payload, zeroed whenever nothing is being offered.
  always_comb begin
    bus.issue_ps1  = '0;
    bus.issue_ps2  = '0;
    bus.issue_pd   = '0;
    bus.issue_imm  = '0;
    bus.issue_ctrl = '0;
    bus.issue_rob  = '0;
    if (issue_vld) begin
      bus.issue_ps1  = ps1_q[sel_idx];
      bus.issue_ps2  = ps2_q[sel_idx];
      bus.issue_pd   = pd_q[sel_idx];
      bus.issue_imm  = imm_q[sel_idx];
      bus.issue_ctrl = ctrl_q[sel_idx];
      bus.issue_rob  = rob_q[sel_idx];
    end
  end

  // Next valid/ready state: dequeue, squash, wakeup, allocation with bypass.
  always_comb begin
    vld_d = vld_q;
    r1_d  = r1_q;
    r2_d  = r2_q;
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_fire && (sel_idx == IDX_W'(i))) begin
        vld_d[i] = 1'b0;
      end else if (bus.mispredict && vld_q[i] &&
                   (age_of(rob_q[i], bus.rob_head) >
                    age_of(bus.mispredict_rob, bus.rob_head))) begin
        vld_d[i] = 1'b0;
      end
      if (tag_hit(ps1_q[i], bus.wb_valid, bus.wb_tag)) r1_d[i] = 1'b1;
      if (tag_hit(ps2_q[i], bus.wb_valid, bus.wb_tag)) r2_d[i] = 1'b1;
    end
    if (disp_fire) begin
      vld_d[free_idx] = 1'b1;
      r1_d[free_idx]  = bus.dispatch_ps1_rdy || (bus.dispatch_ps1 == '0) ||
                        tag_hit(bus.dispatch_ps1, bus.wb_valid, bus.wb_tag);
      r2_d[free_idx]  = bus.dispatch_ps2_rdy || (bus.dispatch_ps2 == '0) ||
                        tag_hit(bus.dispatch_ps2, bus.wb_valid, bus.wb_tag);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + CNT_W'(vld_d[i]);
    end
  end

  // Occupancy and readiness state, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      r1_q  <= '0;
      r2_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      r1_q  <= r1_d;
      r2_q  <= r2_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry payload; only meaningful while the entry is valid, so no reset.
  always_ff @(posedge clk) begin
    if (disp_fire) begin
      ps1_q[free_idx]  <= bus.dispatch_ps1;
      ps2_q[free_idx]  <= bus.dispatch_ps2;
      pd_q[free_idx]   <= bus.dispatch_pd;
      imm_q[free_idx]  <= bus.dispatch_imm;
      ctrl_q[free_idx] <= bus.dispatch_ctrl;
      rob_q[free_idx]  <= bus.dispatch_rob;
    end
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: table of single-op dispatch/wakeup cases
// plus hand sequences for wakeup latency, full queue, ROB wrap, mispredict
// squash and asynchronous reset. Issued ops are checked against a scoreboard.
module tb_alu_reservation_station;
  localparam int DEPTH  = 8;
  localparam int TAG_W  = 7;
  localparam int ROB_W  = 4;
  localparam int CTRL_W = 32;

  typedef struct packed {
    logic [TAG_W-1:0]  ps1;
    logic [TAG_W-1:0]  ps2;
    logic [TAG_W-1:0]  pd;
    logic [31:0]       imm;
    logic [CTRL_W-1:0] ctrl;
    logic [ROB_W-1:0]  rob;
  } op_t;

  typedef struct {
    op_t              op;
    bit               r1;
    bit               r2;
    logic [2:0]       wbv;
    logic [TAG_W-1:0] wbt;
    bit               exp_now;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  op_t  sb[$];
  op_t  got_e;
  vec_t tbl[7];

  alu_reservation_station_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ROB_W(ROB_W), .CTRL_W(CTRL_W)) bus();

  alu_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ROB_W(ROB_W), .CTRL_W(CTRL_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic op_t mk(int ps1, int ps2, int pd, int rob);
    op_t o;
    o.ps1  = TAG_W'(ps1);
    o.ps2  = TAG_W'(ps2);
    o.pd   = TAG_W'(pd);
    o.imm  = 32'h100 + 32'(pd) * 32'd3;
    o.ctrl = CTRL_W'(32'hA500_0000 | (32'(rob) << 8) | 32'(pd));
    o.rob  = ROB_W'(rob);
    return o;
  endfunction

  function automatic vec_t mkv(op_t o, bit r1, bit r2, int wbv, int wbt, bit exp_now);
    vec_t v;
    v.op = o; v.r1 = r1; v.r2 = r2;
    v.wbv = 3'(wbv); v.wbt = TAG_W'(wbt); v.exp_now = exp_now;
    return v;
  endfunction

  task automatic chk(string nm, logic [95:0] act, logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(op_t o, bit r1, bit r2);
    bus.dispatch_valid   = 1'b1;
    bus.dispatch_ps1     = o.ps1;
    bus.dispatch_ps2     = o.ps2;
    bus.dispatch_ps1_rdy = r1;
    bus.dispatch_ps2_rdy = r2;
    bus.dispatch_pd      = o.pd;
    bus.dispatch_imm     = o.imm;
    bus.dispatch_ctrl    = o.ctrl;
    bus.dispatch_rob     = o.rob;
  endtask

  // Scoreboard: every issue handshake must match the next expected op.
  always @(negedge clk) begin
    if (!reset && bus.issue_valid && bus.issue_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL issue_unexpected: got rob %0d expected no issue", bus.issue_rob);
      end else begin
        got_e = sb.pop_front();
        chk("issue_tags", 96'({bus.issue_ps1, bus.issue_ps2, bus.issue_pd, bus.issue_rob}),
                          96'({got_e.ps1, got_e.ps2, got_e.pd, got_e.rob}));
        chk("issue_payload", 96'({bus.issue_imm, bus.issue_ctrl}), 96'({got_e.imm, got_e.ctrl}));
      end
    end
  end

  initial begin
    op_t ops[4];
    op_t o;

    tbl[0] = mkv(mk(5, 0, 40, 0),  1, 0, 0,     0,  1);
    tbl[1] = mkv(mk(9, 10, 41, 1), 0, 1, 0,     0,  0);
    tbl[2] = mkv(mk(3, 12, 42, 2), 1, 0, 3'b001, 12, 1);
    tbl[3] = mkv(mk(20, 21, 43, 3), 0, 0, 3'b010, 20, 0);
    tbl[4] = mkv(mk(22, 23, 44, 4), 0, 1, 3'b100, 22, 1);
    tbl[5] = mkv(mk(0, 0, 45, 5),  0, 0, 0,     0,  1);
    tbl[6] = mkv(mk(30, 31, 46, 6), 0, 1, 0,     30, 0);

    bus.dispatch_valid = 1'b0; bus.dispatch_ps1 = '0; bus.dispatch_ps2 = '0;
    bus.dispatch_ps1_rdy = 1'b0; bus.dispatch_ps2_rdy = 1'b0; bus.dispatch_pd = '0;
    bus.dispatch_imm = '0; bus.dispatch_ctrl = '0; bus.dispatch_rob = '0;
    bus.wb_valid = '0; bus.wb_tag = '0; bus.rob_head = '0;
    bus.mispredict = 1'b0; bus.mispredict_rob = '0; bus.issue_ready = 1'b0;

    #1;
    chk("reset_count", 96'(bus.count), 96'(0));
    chk("reset_dispatch_ready", 96'(bus.dispatch_ready), 96'(0));
    chk("reset_issue_valid", 96'(bus.issue_valid), 96'(0));
    next();
    reset = 1'b0;
    #3;
    chk("idle_dispatch_ready", 96'(bus.dispatch_ready), 96'(1));
    chk("idle_issue_pd_zero", 96'(bus.issue_pd), 96'(0));
    next();

    // Table: single op, optional same-cycle broadcast, then late wakeup.
    for (int i = 0; i < 7; i++) begin
      drive_op(tbl[i].op, tbl[i].r1, tbl[i].r2);
      bus.wb_valid = tbl[i].wbv;
      bus.wb_tag   = {3{tbl[i].wbt}};
      sb.push_back(tbl[i].op);
      #3;
      chk("tbl_dispatch_ready", 96'(bus.dispatch_ready), 96'(1));
      chk("tbl_no_zero_cycle_issue", 96'(bus.issue_valid), 96'(0));
      next();
      bus.dispatch_valid = 1'b0;
      bus.wb_valid = '0;
      #3;
      chk("tbl_eligible", 96'(bus.issue_valid), 96'(tbl[i].exp_now));
      chk("tbl_count_one", 96'(bus.count), 96'(1));
      if (!tbl[i].exp_now) begin
        next();
        bus.wb_valid  = 3'b110;
        bus.wb_tag[1] = tbl[i].op.ps1;
        bus.wb_tag[2] = tbl[i].op.ps2;
        #3;
        chk("tbl_not_before_wake_edge", 96'(bus.issue_valid), 96'(0));
        next();
        bus.wb_valid = '0;
        #3;
        chk("tbl_eligible_after_wake", 96'(bus.issue_valid), 96'(1));
      end
      next();
      bus.issue_ready = 1'b1;
      next();
      bus.issue_ready = 1'b0;
      #3;
      chk("tbl_count_after_issue", 96'(bus.count), 96'(0));
      next();
    end

    // Wakeup on the LSU broadcast three cycles after dispatch.
    o = mk(9, 0, 41, 7);
    drive_op(o, 0, 0);
    sb.push_back(o);
    next();
    bus.dispatch_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("wake_wait_no_issue", 96'(bus.issue_valid), 96'(0));
      next();
    end
    bus.wb_valid  = 3'b100;
    bus.wb_tag[2] = TAG_W'(9);
    #3;
    chk("wake_bcast_cycle", 96'(bus.issue_valid), 96'(0));
    next();
    bus.wb_valid = '0;
    #3;
    chk("wake_next_cycle", 96'(bus.issue_valid), 96'(1));
    next();
    bus.issue_ready = 1'b1;
    next();
    bus.issue_ready = 1'b0;

    // Fill the queue, then issue one while a dispatch is held.
    for (int i = 0; i < DEPTH; i++) begin
      o = mk(i + 1, 0, 50 + i, i);
      drive_op(o, 1, 0);
      sb.push_back(o);
      next();
    end
    o = mk(60, 0, 60, 8);
    drive_op(o, 1, 0);
    sb.push_back(o);
    bus.issue_ready = 1'b1;
    #3;
    chk("full_count", 96'(bus.count), 96'(8));
    chk("full_dispatch_ready", 96'(bus.dispatch_ready), 96'(0));
    next();
    bus.issue_ready = 1'b0;
    #3;
    chk("freed_dispatch_ready", 96'(bus.dispatch_ready), 96'(1));
    chk("freed_count", 96'(bus.count), 96'(7));
    next();
    bus.dispatch_valid = 1'b0;
    #3;
    chk("refill_count", 96'(bus.count), 96'(8));
    bus.issue_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) next();
    bus.issue_ready = 1'b0;
    #3;
    chk("drain_count", 96'(bus.count), 96'(0));
    next();

    // ROB wrap ordering: dispatch youngest first, expect 14, 15, 0, 1.
    bus.rob_head = 4'd14;
    ops[0] = mk(1, 2, 70, 14);
    ops[1] = mk(3, 4, 71, 15);
    ops[2] = mk(5, 6, 72, 0);
    ops[3] = mk(7, 8, 73, 1);
    for (int i = 0; i < 4; i++) sb.push_back(ops[i]);
    for (int i = 3; i >= 0; i--) begin
      drive_op(ops[i], 1, 1);
      next();
    end
    bus.dispatch_valid = 1'b0;
    #3;
    chk("wrap_count", 96'(bus.count), 96'(4));
    chk("wrap_head_oldest", 96'(bus.issue_rob), 96'(14));
    bus.issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) next();
    bus.issue_ready = 1'b0;
    #3;
    chk("wrap_drain_count", 96'(bus.count), 96'(0));
    next();

    // Mispredict on rob 3 squashes 5 and 6; rob 3 wakes in the same cycle.
    bus.rob_head = 4'd2;
    ops[0] = mk(1, 2, 80, 6);
    ops[1] = mk(3, 4, 81, 5);
    ops[2] = mk(44, 5, 82, 3);
    ops[3] = mk(6, 7, 83, 2);
    sb.push_back(ops[3]);
    sb.push_back(ops[2]);
    for (int i = 0; i < 4; i++) begin
      drive_op(ops[i], (i != 2), 1);
      next();
    end
    bus.dispatch_valid = 1'b0;
    #3;
    chk("mp_pre_count", 96'(bus.count), 96'(4));
    next();
    bus.mispredict     = 1'b1;
    bus.mispredict_rob = 4'd3;
    bus.issue_ready    = 1'b1;
    bus.wb_valid       = 3'b001;
    bus.wb_tag[0]      = TAG_W'(44);
    drive_op(mk(9, 9, 84, 7), 1, 1);
    #3;
    chk("mp_issue_valid", 96'(bus.issue_valid), 96'(0));
    chk("mp_dispatch_ready", 96'(bus.dispatch_ready), 96'(0));
    next();
    bus.mispredict     = 1'b0;
    bus.wb_valid       = '0;
    bus.dispatch_valid = 1'b0;
    bus.issue_ready    = 1'b0;
    #3;
    chk("mp_post_count", 96'(bus.count), 96'(2));
    chk("mp_oldest_rob", 96'(bus.issue_rob), 96'(2));
    bus.issue_ready = 1'b1;
    next();
    next();
    bus.issue_ready = 1'b0;
    #3;
    chk("mp_drain_count", 96'(bus.count), 96'(0));
    next();

    // Asynchronous reset between clock edges.
    bus.rob_head = '0;
    drive_op(mk(1, 2, 90, 0), 1, 1);
    next();
    bus.dispatch_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_count", 96'(bus.count), 96'(0));
    chk("async_rst_issue_valid", 96'(bus.issue_valid), 96'(0));
    chk("async_rst_dispatch_ready", 96'(bus.dispatch_ready), 96'(0));
    next();
    reset = 1'b0;
    #3;
    chk("post_rst_count", 96'(bus.count), 96'(0));
    chk("post_rst_dispatch_ready", 96'(bus.dispatch_ready), 96'(1));
    next();

    chk("scoreboard_drained", 96'(sb.size()), 96'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
